traffic_intersection_ctrl: RTL
==============================

TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the countdown and duration values.
REQ-002 SHALL have parameter GREEN_TIME, default 20: green duration in ticks, for each direction.
REQ-003 SHALL have parameter YELLOW_TIME, default 3: yellow duration in ticks.
REQ-004 SHALL have parameter ALLRED_TIME, default 2: all-red clearance duration in ticks.
REQ-005 SHALL have parameter WALK_TIME, default 10: pedestrian walk duration in ticks.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port tick, input, 1 bit: one-cycle count-enable strobe (e.g. 1 Hz).
REQ-009 SHALL have port ped_req, input, 1 bit: pedestrian request, level-sampled every cycle.
REQ-010 SHALL have port manual_override, input, 1 bit: forces the phase from manual_phase.
REQ-011 SHALL have port manual_phase, input, 3 bits: requested phase code (REQ-016).
REQ-012 SHALL have port ns_light, output, 3 bits: north-south lamps {R,Y,G}, one-hot.
REQ-013 SHALL have port ew_light, output, 3 bits: east-west lamps {R,Y,G}, one-hot.
REQ-014 SHALL have outputs walk (1 bit), ped_pending (1 bit), phase (3 bits) and time_remaining (CNT_W bits).

Function
REQ-015 Every duration parameter SHALL be in the range 1..2^CNT_W-1; the block SHALL raise an elaboration error otherwise.
REQ-016 Phase codes SHALL be:
- 0 NS_G, 1 NS_Y, 2 AR_A, 3 EW_G, 4 EW_Y, 5 AR_B, 6 PED_WALK.
- Code 7 is illegal.
REQ-017 Automatic sequence SHALL be NS_G->NS_Y->AR_A->EW_G->EW_Y->AR_B.
- From AR_B: go to PED_WALK if ped_pending=1, else to NS_G.
- PED_WALK->NS_G.
REQ-018 On entry to any phase, time_remaining SHALL load that phase's duration:
- G phases: GREEN_TIME; Y phases: YELLOW_TIME; AR phases: ALLRED_TIME; PED_WALK: WALK_TIME.
REQ-019 Countdown per cycle with tick=1 and manual_override=0:
- time_remaining>1: decrement by 1.
- time_remaining==1: advance to the next phase and load its duration in the same edge.
- Each phase therefore lasts exactly its duration in ticks.
REQ-020 With tick=0, phase and time_remaining SHALL hold.
REQ-021 Lamp decode, from the registered phase only:
- NS_G: ns=G, ew=R.
- NS_Y: ns=Y, ew=R.
- EW_G: ew=G, ns=R.
- EW_Y: ew=Y, ns=R.
- AR_A, AR_B, PED_WALK: both R.
- walk=1 only in PED_WALK.
REQ-022 Pedestrian latch:
- ped_pending SHALL set on any cycle with ped_req=1.
- It SHALL clear on the edge entering PED_WALK.
- If ped_req=1 on that same edge, set dominates and ped_pending stays 1.
REQ-023 While manual_override=1:
- Each edge: phase<=manual_phase and time_remaining<=that phase's duration.
- tick SHALL be ignored; ped_pending SHALL still latch but SHALL NOT clear.
- manual_phase=7 SHALL be treated as AR_B.
REQ-024 On manual_override deassertion, countdown SHALL resume from the full duration of the held phase, and the automatic sequence SHALL continue from that phase.
REQ-025 manual_override SHALL take priority over tick in the same cycle.
REQ-026 There SHALL be no combinational path from any input to any output.

Reset
REQ-027 While reset=1, regardless of clk, outputs SHALL be:
- phase=AR_B, time_remaining=ALLRED_TIME, ped_pending=0.
- ns_light=ew_light=3'b100, walk=0.
REQ-028 Reset asserted mid-phase SHALL abandon the countdown immediately, with no partial-phase completion after release.
REQ-029 The first tick after reset release SHALL decrement from ALLRED_TIME; with defaults, NS_G is entered on the 2nd tick.

Verification
REQ-030 Reset, no ped_req, defaults -> phase sequence 5,0,1,2,3,4,5 with dwell 2/20/3/2/20/3/2 ticks.
REQ-031 One-cycle ped_req pulse during EW_G -> ped_pending=1; after AR_B, PED_WALK with walk=1 for 10 ticks, then NS_G; ped_pending=0 from PED_WALK entry.
REQ-032 manual_override=1, manual_phase=3 mid-NS_G, 5 ticks applied -> phase=3, time_remaining=20 held; release -> EW_G lasts 20 further ticks, then EW_Y.
REQ-033 manual_phase=7 under override -> phase=5, both lamps R, time_remaining=2.
REQ-034 ped_req held high across the PED_WALK entry edge -> ped_pending remains 1 and a second PED_WALK follows the next AR_B.
REQ-035 Reset asserted with NS_G at time_remaining=7 -> immediate phase=5, time_remaining=2, ped_pending=0, ns_light=ew_light=3'b100.

Source files
------------

// File: rtl/traffic_intersection_ctrl.sv
// Two-way intersection signal controller with all-red clearance, pedestrian walk
// phase and manual phase override. Lamps are decoded from the registered phase only.
module traffic_intersection_ctrl #(
  parameter int CNT_W       = 8,
  parameter int GREEN_TIME  = 20,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int WALK_TIME   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             ped_req,
  input  logic             manual_override,
  input  logic [2:0]       manual_phase,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic             ped_pending,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] time_remaining
);

  localparam longint MAX_DUR = (longint'(1) << CNT_W) - 1;

  if (GREEN_TIME < 1 || GREEN_TIME > MAX_DUR) begin : g_bad_green
    $error("GREEN_TIME out of range 1..2^CNT_W-1");
  end
  if (YELLOW_TIME < 1 || YELLOW_TIME > MAX_DUR) begin : g_bad_yellow
    $error("YELLOW_TIME out of range 1..2^CNT_W-1");
  end
  if (ALLRED_TIME < 1 || ALLRED_TIME > MAX_DUR) begin : g_bad_allred
    $error("ALLRED_TIME out of range 1..2^CNT_W-1");
  end
  if (WALK_TIME < 1 || WALK_TIME > MAX_DUR) begin : g_bad_walk
    $error("WALK_TIME out of range 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] G_DUR  = CNT_W'(GREEN_TIME);
  localparam logic [CNT_W-1:0] Y_DUR  = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] AR_DUR = CNT_W'(ALLRED_TIME);
  localparam logic [CNT_W-1:0] W_DUR  = CNT_W'(WALK_TIME);

  typedef enum logic [2:0] {
    NS_G     = 3'd0,
    NS_Y     = 3'd1,
    AR_A     = 3'd2,
    EW_G     = 3'd3,
    EW_Y     = 3'd4,
    AR_B     = 3'd5,
    PED_WALK = 3'd6
  } phase_t;

  phase_t           phase_q, phase_d, nxt;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             pend_q, pend_d;

  function automatic logic [CNT_W-1:0] phase_dur(input phase_t p);
    case (p)
      NS_G, EW_G: return G_DUR;
      NS_Y, EW_Y: return Y_DUR;
      PED_WALK:   return W_DUR;
      default:    return AR_DUR;
    endcase
  endfunction

  function automatic phase_t next_phase(input phase_t p, input logic pend);
    case (p)
      NS_G:    return NS_Y;
      NS_Y:    return AR_A;
      AR_A:    return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return AR_B;
      AR_B:    return pend ? PED_WALK : NS_G;
      default: return NS_G;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= AR_B;
      rem_q   <= AR_DUR;
      pend_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
    end
  end

  // Override wins over tick; only an automatic entry into the walk phase may clear the latch.
  always_comb begin
    phase_d = phase_q;
    rem_d   = rem_q;
    pend_d  = pend_q | ped_req;
    nxt     = next_phase(phase_q, pend_q);
    if (manual_override) begin
      phase_d = (manual_phase == 3'd7) ? AR_B : phase_t'(manual_phase);
      rem_d   = phase_dur(phase_d);
    end else if (tick) begin
      if (rem_q > CNT_W'(1)) begin
        rem_d = rem_q - CNT_W'(1);
      end else begin
        phase_d = nxt;
        rem_d   = phase_dur(nxt);
        if (nxt == PED_WALK) pend_d = ped_req;
      end
    end
  end

  always_comb begin
    ns_light = 3'b100;
    ew_light = 3'b100;
    walk     = 1'b0;
    case (phase_q)
      NS_G:     ns_light = 3'b001;
      NS_Y:     ns_light = 3'b010;
      EW_G:     ew_light = 3'b001;
      EW_Y:     ew_light = 3'b010;
      PED_WALK: walk     = 1'b1;
      default:  ;
    endcase
  end

  assign phase          = phase_q;
  assign time_remaining = rem_q;
  assign ped_pending    = pend_q;

endmodule
